// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: N accounts with balances, PIN check with lockout,
// balance/deposit/withdraw operations, saturating deposits and inactivity timeout.
//
// state    | meaning
// IDLE     | no session, waiting for a card
// WAIT_PIN | card accepted, waiting for a PIN entry
// MENU     | authenticated, waiting for an operation
// DEP_WAIT | deposit selected, waiting for the cash unit
// OP_DONE  | operation finished, waiting for another/eject
// EJECT    | session over, waiting for the card to be removed
module atm_multi_account_ctrl #(
  parameter int          NUM_ACCOUNTS = 4,
  parameter int          PIN_W        = 4,
  parameter int          PIN_BASE     = 10,
  parameter int          AMT_W        = 7,
  parameter int          BAL_W        = 32,
  parameter int unsigned INIT_BAL     = 1000,
  parameter int          MAX_TRIES    = 3,
  parameter int          TIMEOUT_CYC  = 1000,
  localparam int         AID_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cardIn,
  input  logic [AID_W-1:0] account_id,
  input  logic [PIN_W-1:0] password,
  input  logic             pin_valid,
  input  logic [1:0]       opCode,
  input  logic             op_valid,
  input  logic [AMT_W-1:0] inputAmount,
  input  logic             moneyDeposited,
  input  logic             Another_Operation,
  input  logic             ejectCard,
  output logic             correctPassword,
  output logic             Balance_Shown,
  output logic             Deposited_Successfully,
  output logic             Withdrawed_Successfully,
  output logic             Insufficient_Funds,
  output logic             Card_Locked,
  output logic             ATM_Usage_Finished,
  output logic [BAL_W-1:0] Current_Balance
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PIN, S_MENU, S_DEP_WAIT, S_OP_DONE, S_EJECT
  } state_t;

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [BAL_W-1:0] INIT_BAL_V = BAL_W'(INIT_BAL);

  state_t                  state_q;
  logic [AID_W-1:0]        acct_q;
  logic [TRY_W-1:0]        tries_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [AMT_W-1:0]        amt_q;
  logic [NUM_ACCOUNTS-1:0] locked_q;
  logic [BAL_W-1:0]        bal_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        cur_bal_q;
  logic cp_q, shown_q, dep_ok_q, wd_ok_q, nsf_q, locked_pulse_q, fin_q;

  logic [BAL_W-1:0] bal_cur, amt_ext, amt_in_ext, dep_sat;
  logic [BAL_W:0]   dep_sum;
  logic [PIN_W-1:0] pin_exp;
  logic             active, strobe, force_eject;

  assign bal_cur    = bal_q[acct_q];
  assign amt_ext    = BAL_W'(amt_q);
  assign amt_in_ext = BAL_W'(inputAmount);
  assign dep_sum    = {1'b0, bal_cur} + {1'b0, amt_ext};
  assign dep_sat    = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
  assign pin_exp    = PIN_W'(PIN_BASE + int'(acct_q));
  assign active     = (state_q inside {S_WAIT_PIN, S_MENU, S_DEP_WAIT, S_OP_DONE});

  always_comb begin
    strobe = 1'b0;
    unique case (state_q)
      S_WAIT_PIN: strobe = pin_valid;
      S_MENU:     strobe = op_valid;
      S_DEP_WAIT: strobe = moneyDeposited;
      S_OP_DONE:  strobe = Another_Operation;
      default:    strobe = 1'b0;
    endcase
  end

  // Abort beats every strobe; the timer only expires on a cycle with no strobe.
  assign force_eject = active & (ejectCard | ~cardIn | (~strobe & (tmr_q == '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      acct_q         <= '0;
      tries_q        <= '0;
      tmr_q          <= TMR_LOAD;
      amt_q          <= '0;
      locked_q       <= '0;
      cur_bal_q      <= '0;
      cp_q           <= 1'b0;
      shown_q        <= 1'b0;
      dep_ok_q       <= 1'b0;
      wd_ok_q        <= 1'b0;
      nsf_q          <= 1'b0;
      locked_pulse_q <= 1'b0;
      fin_q          <= 1'b0;
      for (int k = 0; k < NUM_ACCOUNTS; k++) bal_q[k] <= INIT_BAL_V;
    end else begin
      shown_q        <= 1'b0;
      dep_ok_q       <= 1'b0;
      wd_ok_q        <= 1'b0;
      nsf_q          <= 1'b0;
      locked_pulse_q <= 1'b0;
      fin_q          <= 1'b0;
      if (active) tmr_q <= strobe ? TMR_LOAD : tmr_q - TMR_W'(1);

      if (force_eject) begin
        state_q   <= S_EJECT;
        fin_q     <= 1'b1;
        cp_q      <= 1'b0;
        cur_bal_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cur_bal_q <= '0;
            if (cardIn) begin
              acct_q <= account_id;
              if (locked_q[account_id]) begin
                locked_pulse_q <= 1'b1;
                fin_q          <= 1'b1;
                state_q        <= S_EJECT;
              end else begin
                tries_q <= '0;
                tmr_q   <= TMR_LOAD;
                state_q <= S_WAIT_PIN;
              end
            end
          end
          S_WAIT_PIN: begin
            if (pin_valid) begin
              if (password == pin_exp) begin
                cp_q      <= 1'b1;
                cur_bal_q <= bal_cur;
                state_q   <= S_MENU;
              end else if (tries_q == TRY_LAST) begin
                locked_q[acct_q] <= 1'b1;
                locked_pulse_q   <= 1'b1;
                fin_q            <= 1'b1;
                state_q          <= S_EJECT;
              end else begin
                tries_q <= tries_q + TRY_W'(1);
              end
            end
          end
          S_MENU: begin
            if (op_valid) begin
              unique case (opCode)
                2'b00: begin
                  shown_q <= 1'b1;
                  state_q <= S_OP_DONE;
                end
                2'b01: begin
                  amt_q   <= inputAmount;
                  state_q <= S_DEP_WAIT;
                end
                2'b10: begin
                  if (amt_in_ext <= bal_cur) begin
                    bal_q[acct_q] <= bal_cur - amt_in_ext;
                    cur_bal_q     <= bal_cur - amt_in_ext;
                    wd_ok_q       <= 1'b1;
                  end else begin
                    nsf_q <= 1'b1;
                  end
                  state_q <= S_OP_DONE;
                end
                default: begin
                  fin_q     <= 1'b1;
                  cp_q      <= 1'b0;
                  cur_bal_q <= '0;
                  state_q   <= S_EJECT;
                end
              endcase
            end
          end
          S_DEP_WAIT: begin
            if (moneyDeposited) begin
              bal_q[acct_q] <= dep_sat;
              cur_bal_q     <= dep_sat;
              dep_ok_q      <= 1'b1;
              state_q       <= S_OP_DONE;
            end
          end
          S_OP_DONE: begin
            if (Another_Operation) state_q <= S_MENU;
          end
          default: begin
            if (!cardIn) state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign correctPassword         = cp_q;
  assign Balance_Shown           = shown_q;
  assign Deposited_Successfully  = dep_ok_q;
  assign Withdrawed_Successfully = wd_ok_q;
  assign Insufficient_Funds      = nsf_q;
  assign Card_Locked             = locked_pulse_q;
  assign ATM_Usage_Finished      = fin_q;
  assign Current_Balance         = cur_bal_q;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Bench for atm_multi_account_ctrl: per-cycle vector table run through a scoreboard
// on a default instance and a small-balance/short-timeout instance.
module tb_atm_multi_account_ctrl;

  typedef struct packed {
    logic       card;
    logic [1:0] aid;
    logic [3:0] pin;
    logic       pv;
    logic [1:0] op;
    logic       ov;
    logic [6:0] amt;
    logic       md;
    logic       ao;
    logic       ej;
  } in_t;

  // pul = {Balance_Shown, Deposited, Withdrawed, Insufficient, Card_Locked, Finished}
  typedef struct packed {
    logic        cp;
    logic [5:0]  pul;
    logic [31:0] bal;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    bit    sel;
    string tag;
  } vec_t;

  typedef struct {
    out_t  o;
    bit    sel;
    string tag;
  } sb_t;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_BS   = 6'b100000;
  localparam logic [5:0] P_DS   = 6'b010000;
  localparam logic [5:0] P_WS   = 6'b001000;
  localparam logic [5:0] P_INF  = 6'b000100;
  localparam logic [5:0] P_CL   = 6'b000010;
  localparam logic [5:0] P_FIN  = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       cardIn;
  logic [1:0] account_id;
  logic [3:0] password;
  logic       pin_valid;
  logic [1:0] opCode;
  logic       op_valid;
  logic [6:0] inputAmount;
  logic       moneyDeposited, Another_Operation, ejectCard;

  logic        cp_a, bs_a, ds_a, ws_a, inf_a, cl_a, fin_a;
  logic [31:0] bal_a;
  logic        cp_b, bs_b, ds_b, ws_b, inf_b, cl_b, fin_b;
  logic [10:0] bal_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  sb_t  exp_q[$];
  logic [1:0] g_aid = 2'd0;
  bit         g_sel = 1'b0;
  string      g_tag = "init";

  always #5 clk = ~clk;

  atm_multi_account_ctrl dut_a (
    .clk(clk), .reset(reset), .cardIn(cardIn), .account_id(account_id),
    .password(password), .pin_valid(pin_valid), .opCode(opCode), .op_valid(op_valid),
    .inputAmount(inputAmount), .moneyDeposited(moneyDeposited),
    .Another_Operation(Another_Operation), .ejectCard(ejectCard),
    .correctPassword(cp_a), .Balance_Shown(bs_a), .Deposited_Successfully(ds_a),
    .Withdrawed_Successfully(ws_a), .Insufficient_Funds(inf_a), .Card_Locked(cl_a),
    .ATM_Usage_Finished(fin_a), .Current_Balance(bal_a)
  );

  atm_multi_account_ctrl #(.BAL_W(11), .INIT_BAL(2040), .TIMEOUT_CYC(20)) dut_b (
    .clk(clk), .reset(reset), .cardIn(cardIn), .account_id(account_id),
    .password(password), .pin_valid(pin_valid), .opCode(opCode), .op_valid(op_valid),
    .inputAmount(inputAmount), .moneyDeposited(moneyDeposited),
    .Another_Operation(Another_Operation), .ejectCard(ejectCard),
    .correctPassword(cp_b), .Balance_Shown(bs_b), .Deposited_Successfully(ds_b),
    .Withdrawed_Successfully(ws_b), .Insufficient_Funds(inf_b), .Card_Locked(cl_b),
    .ATM_Usage_Finished(fin_b), .Current_Balance(bal_b)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  function automatic in_t f_wait(logic card);
    in_t x = '0;
    x.card = card;
    x.aid  = g_aid;
    return x;
  endfunction

  function automatic in_t f_pin(logic [3:0] pin);
    in_t x = f_wait(1'b1);
    x.pv  = 1'b1;
    x.pin = pin;
    return x;
  endfunction

  function automatic in_t f_op(logic [1:0] op, logic [6:0] amt);
    in_t x = f_wait(1'b1);
    x.ov  = 1'b1;
    x.op  = op;
    x.amt = amt;
    return x;
  endfunction

  function automatic in_t f_dep();
    in_t x = f_wait(1'b1);
    x.md = 1'b1;
    return x;
  endfunction

  function automatic in_t f_another();
    in_t x = f_wait(1'b1);
    x.ao = 1'b1;
    return x;
  endfunction

  function automatic in_t f_eject();
    in_t x = f_wait(1'b1);
    x.ej = 1'b1;
    return x;
  endfunction

  function automatic out_t mk_out(logic cp, logic [5:0] p, int bal);
    out_t o;
    o.cp  = cp;
    o.pul = p;
    o.bal = 32'(bal);
    return o;
  endfunction

  function automatic void add(in_t i, logic cp, logic [5:0] p, int bal);
    vec_t v;
    v.i   = i;
    v.o   = mk_out(cp, p, bal);
    v.sel = g_sel;
    v.tag = $sformatf("%s#%0d", g_tag, vecs.size());
    vecs.push_back(v);
  endfunction

  function automatic out_t sample(bit sel);
    out_t o;
    if (sel) begin
      o.cp  = cp_b;
      o.pul = {bs_b, ds_b, ws_b, inf_b, cl_b, fin_b};
      o.bal = 32'(bal_b);
    end else begin
      o.cp  = cp_a;
      o.pul = {bs_a, ds_a, ws_a, inf_a, cl_a, fin_a};
      o.bal = bal_a;
    end
    return o;
  endfunction

  task automatic check(out_t exp, bit sel, string tag);
    out_t act = sample(sel);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cp=%0b pulses=%06b bal=%0d, expected cp=%0b pulses=%06b bal=%0d",
               tag, act.cp, act.pul, act.bal, exp.cp, exp.pul, exp.bal);
    end
  endtask

  task automatic drive(in_t x);
    cardIn            = x.card;
    account_id        = x.aid;
    password          = x.pin;
    pin_valid         = x.pv;
    opCode            = x.op;
    op_valid          = x.ov;
    inputAmount       = x.amt;
    moneyDeposited    = x.md;
    Another_Operation = x.ao;
    ejectCard         = x.ej;
  endtask

  task automatic pop_check();
    sb_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.o, e.sel, e.tag);
    end
  endtask

  task automatic run_vecs();
    sb_t e;
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      pop_check();
      drive(vecs[n].i);
      e.o   = vecs[n].o;
      e.sel = vecs[n].sel;
      e.tag = vecs[n].tag;
      exp_q.push_back(e);
    end
    @(negedge clk);
    pop_check();
    vecs.delete();
  endtask

  initial begin
    int bal;
    reset = 1'b0;
    drive(f_wait(1'b0));
    repeat (3) @(negedge clk);
    check(mk_out(1'b0, P_NONE, 0), 1'b0, "reset_a");
    check(mk_out(1'b0, P_NONE, 0), 1'b1, "reset_b");
    reset = 1'b1;

    // ---- default instance ----
    g_sel = 1'b0;
    g_tag = "balance_acct0"; g_aid = 2'd0;
    add(f_wait(1'b1),      1'b0, P_NONE, 0);
    add(f_pin(4'd10),      1'b1, P_NONE, 1000);
    add(f_op(2'd0, 7'd0),  1'b1, P_BS,   1000);
    add(f_eject(),         1'b0, P_FIN,  0);
    add(f_wait(1'b0),      1'b0, P_NONE, 0);

    g_tag = "withdraw_acct1"; g_aid = 2'd1;
    add(f_wait(1'b1),       1'b0, P_NONE, 0);
    add(f_pin(4'd11),       1'b1, P_NONE, 1000);
    add(f_op(2'd2, 7'd100), 1'b1, P_WS,   900);
    bal = 900;
    for (int k = 0; k < 8; k++) begin
      add(f_another(), 1'b1, P_NONE, bal);
      if (bal >= 127) begin
        bal -= 127;
        add(f_op(2'd2, 7'd127), 1'b1, P_WS, bal);
      end else begin
        add(f_op(2'd2, 7'd127), 1'b1, P_INF, bal);
      end
    end
    add(f_another(),       1'b1, P_NONE, 11);
    add(f_op(2'd2, 7'd11), 1'b1, P_WS,   0);
    add(f_another(),       1'b1, P_NONE, 0);
    add(f_op(2'd1, 7'd0),  1'b1, P_NONE, 0);
    add(f_dep(),           1'b1, P_DS,   0);
    add(f_another(),       1'b1, P_NONE, 0);
    add(f_op(2'd3, 7'd0),  1'b0, P_FIN,  0);
    add(f_wait(1'b0),      1'b0, P_NONE, 0);

    g_tag = "lockout_acct2"; g_aid = 2'd2;
    add(f_wait(1'b1),  1'b0, P_NONE,       0);
    add(f_pin(4'd0),   1'b0, P_NONE,       0);
    add(f_pin(4'd5),   1'b0, P_NONE,       0);
    add(f_pin(4'd13),  1'b0, P_CL | P_FIN, 0);
    add(f_wait(1'b1),  1'b0, P_NONE,       0);
    add(f_wait(1'b0),  1'b0, P_NONE,       0);
    add(f_wait(1'b1),  1'b0, P_CL | P_FIN, 0);
    add(f_wait(1'b0),  1'b0, P_NONE,       0);

    g_tag = "retry_reset_acct3"; g_aid = 2'd3;
    add(f_wait(1'b1), 1'b0, P_NONE, 0);
    add(f_pin(4'd0),  1'b0, P_NONE, 0);
    add(f_pin(4'd0),  1'b0, P_NONE, 0);
    add(f_eject(),    1'b0, P_FIN,  0);
    add(f_wait(1'b0), 1'b0, P_NONE, 0);
    add(f_wait(1'b1), 1'b0, P_NONE, 0);
    add(f_pin(4'd1),  1'b0, P_NONE, 0);
    add(f_pin(4'd1),  1'b0, P_NONE, 0);
    add(f_pin(4'd13), 1'b1, P_NONE, 1000);
    add(f_wait(1'b0), 1'b0, P_FIN,  0);
    add(f_wait(1'b0), 1'b0, P_NONE, 0);

    g_tag = "deposit_abort_acct0"; g_aid = 2'd0;
    add(f_wait(1'b1),      1'b0, P_NONE, 0);
    add(f_pin(4'd10),      1'b1, P_NONE, 1000);
    add(f_op(2'd1, 7'd50), 1'b1, P_NONE, 1000);
    add(f_wait(1'b1),      1'b1, P_NONE, 1000);
    begin
      in_t x = f_dep();
      x.ej = 1'b1;
      add(x, 1'b0, P_FIN, 0);
    end
    add(f_wait(1'b0),      1'b0, P_NONE, 0);
    add(f_wait(1'b1),      1'b0, P_NONE, 0);
    add(f_pin(4'd10),      1'b1, P_NONE, 1000);
    add(f_op(2'd0, 7'd0),  1'b1, P_BS,   1000);
    begin
      in_t x = f_another();
      x.ej = 1'b1;
      add(x, 1'b0, P_FIN, 0);
    end
    add(f_wait(1'b0),      1'b0, P_NONE, 0);
    run_vecs();

    // asynchronous reset in the middle of an authenticated session
    g_aid = 2'd0;
    @(negedge clk); drive(f_wait(1'b1));
    @(negedge clk); drive(f_pin(4'd10));
    @(negedge clk); drive(f_wait(1'b1));
    check(mk_out(1'b1, P_NONE, 1000), 1'b0, "pre_reset_session");
    #2 reset = 1'b0;
    #1;
    check(mk_out(1'b0, P_NONE, 0), 1'b0, "mid_reset_a");
    check(mk_out(1'b0, P_NONE, 0), 1'b1, "mid_reset_b");
    drive(f_wait(1'b0));
    @(negedge clk); reset = 1'b1;

    // ---- BAL_W=11, INIT_BAL=2040, TIMEOUT_CYC=20 instance ----
    g_sel = 1'b1;
    g_tag = "saturate_acct1"; g_aid = 2'd1;
    add(f_wait(1'b1),       1'b0, P_NONE, 0);
    add(f_pin(4'd11),       1'b1, P_NONE, 2040);
    add(f_op(2'd1, 7'd20),  1'b1, P_NONE, 2040);
    add(f_dep(),            1'b1, P_DS,   2047);
    add(f_another(),        1'b1, P_NONE, 2047);
    add(f_op(2'd2, 7'd100), 1'b1, P_WS,   1947);
    add(f_another(),        1'b1, P_NONE, 1947);
    add(f_op(2'd1, 7'd50),  1'b1, P_NONE, 1947);
    add(f_dep(),            1'b1, P_DS,   1997);
    add(f_another(),        1'b1, P_NONE, 1997);
    add(f_op(2'd1, 7'd127), 1'b1, P_NONE, 1997);
    add(f_dep(),            1'b1, P_DS,   2047);
    add(f_another(),        1'b1, P_NONE, 2047);
    add(f_op(2'd2, 7'd0),   1'b1, P_WS,   2047);
    add(f_another(),        1'b1, P_NONE, 2047);
    add(f_op(2'd3, 7'd0),   1'b0, P_FIN,  0);
    add(f_wait(1'b0),       1'b0, P_NONE, 0);

    g_tag = "timeout_acct0"; g_aid = 2'd0;
    add(f_wait(1'b1),  1'b0, P_NONE, 0);
    add(f_pin(4'd10),  1'b1, P_NONE, 2040);
    for (int k = 0; k < 19; k++) add(f_wait(1'b1), 1'b1, P_NONE, 2040);
    add(f_wait(1'b1),  1'b0, P_FIN,  0);
    add(f_wait(1'b1),  1'b0, P_NONE, 0);
    add(f_wait(1'b0),  1'b0, P_NONE, 0);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
